load_store_initiator: RTL and testbench

CPU-side initiator for the byte-serial memory controller. It accepts one decoded load/store request from the execute stage and computes the effective address. It validates funct3 and alignment, then drives the controller's start/address/mode/write_enable/write_data interface. It waits for done, then returns load data to register writeback or reports a fault. One request is in flight at a time.

---
 rtl/load_store_initiator.sv | 187 ++++++++++++++++++
 tb/tb_load_store_initiator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_initiator.sv
// Load/store initiator: accepts one decoded RV32I memory request, checks it, drives the
// byte-serial memory controller and returns load data to writeback or reports a fault.
module load_store_initiator #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter bit CHECK_ALIGN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_rd,
  output logic        mem_start,
  output logic [31:0] mem_address,
  output logic [2:0]  mem_mode,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic        mem_done,
  input  logic [31:0] mem_read_data,
  input  logic        mem_active,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_MIS_LOAD  = 2'd0;
  localparam logic [1:0] CAUSE_MIS_STORE = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT   = 2'd3;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       funct3_q, funct3_d;
  logic             store_q, store_d;
  logic [31:0]      data_q, data_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [1:0]       fault_cause_q, fault_cause_d;
  logic [31:0]      fault_addr_q, fault_addr_d;

  logic [31:0] req_addr;
  logic        funct3_legal;
  logic        misaligned;
  logic        mem_drive;

  // Controller activity is informational only; it never steers this block.
  logic unused_mem_active;
  assign unused_mem_active = mem_active;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req_addr     = req_base + req_offset;
    funct3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = !req_store;
      default:                funct3_legal = 1'b0;
    endcase
    misaligned = CHECK_ALIGN &&
                 (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    addr_d        = addr_q;
    funct3_d      = funct3_q;
    store_d       = store_q;
    data_d        = data_q;
    rd_d          = rd_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    fault_cause_d = fault_cause_q;
    fault_addr_d  = fault_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          funct3_d = req_funct3;
          store_d  = req_store;
          data_d   = req_store_data;
          rd_d     = req_rd;
          // Illegal funct3 is reported ahead of misalignment.
          if (!funct3_legal) begin
            state_d       = S_FAULT;
            fault_cause_d = CAUSE_ILLEGAL;
            fault_addr_d  = req_addr;
          end else if (misaligned) begin
            state_d       = S_FAULT;
            fault_cause_d = req_store ? CAUSE_MIS_STORE : CAUSE_MIS_LOAD;
            fault_addr_d  = req_addr;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_done) begin
          if (store_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
            if (rd_q != 5'd0) begin
              wb_rd_d   = rd_q;
              wb_data_d = mem_read_data;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_FAULT;
          fault_cause_d = CAUSE_TIMEOUT;
          fault_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      funct3_q      <= '0;
      store_q       <= 1'b0;
      data_q        <= '0;
      rd_q          <= '0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      funct3_q      <= funct3_d;
      store_q       <= store_d;
      data_q        <= data_d;
      rd_q          <= rd_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      fault_cause_q <= fault_cause_d;
      fault_addr_q  <= fault_addr_d;
    end
  end

  assign mem_drive        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign req_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign mem_start        = (state_q == S_ISSUE);
  assign mem_address      = mem_drive ? addr_q   : 32'd0;
  assign mem_mode         = mem_drive ? funct3_q : 3'd0;
  assign mem_write_enable = mem_drive && store_q;
  assign mem_write_data   = mem_drive ? data_q   : 32'd0;
  assign wb_valid         = (state_q == S_RESP) && (rd_q != 5'd0);
  assign wb_rd            = wb_rd_q;
  assign wb_data          = wb_data_q;
  assign fault            = (state_q == S_FAULT);
  assign fault_cause      = fault_cause_q;
  assign fault_addr       = fault_addr_q;

endmodule

// File: tb/tb_load_store_initiator.sv
// Directed bench for load_store_initiator: table of single transactions plus hand-written
// sequences for reset-in-flight and the no-alignment-check variant.
module tb_load_store_initiator;

  localparam int NEVER = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_offset, req_store_data;
  logic [4:0]  req_rd;
  logic        mem_done, mem_active;
  logic [31:0] mem_read_data;

  logic        req_ready, mem_start, mem_write_enable, wb_valid, fault, busy;
  logic [31:0] mem_address, mem_write_data, wb_data, fault_addr;
  logic [2:0]  mem_mode;
  logic [4:0]  wb_rd;
  logic [1:0]  fault_cause;

  logic        na_req_ready, na_mem_start, na_mem_write_enable, na_wb_valid, na_fault, na_busy;
  logic [31:0] na_mem_address, na_mem_write_data, na_wb_data, na_fault_addr;
  logic [2:0]  na_mem_mode;
  logic [4:0]  na_wb_rd;
  logic [1:0]  na_fault_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_initiator #(.TIMEOUT_CYCLES(16), .CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_offset(req_offset), .req_store_data(req_store_data), .req_rd(req_rd),
    .mem_start(mem_start), .mem_address(mem_address), .mem_mode(mem_mode),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_done(mem_done), .mem_read_data(mem_read_data), .mem_active(mem_active),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr), .busy(busy)
  );

  load_store_initiator #(.TIMEOUT_CYCLES(16), .CHECK_ALIGN(1'b0)) dut_na (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(na_req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_base(req_base),
    .req_offset(req_offset), .req_store_data(req_store_data), .req_rd(req_rd),
    .mem_start(na_mem_start), .mem_address(na_mem_address), .mem_mode(na_mem_mode),
    .mem_write_enable(na_mem_write_enable), .mem_write_data(na_mem_write_data),
    .mem_done(mem_done), .mem_read_data(mem_read_data), .mem_active(mem_active),
    .wb_valid(na_wb_valid), .wb_rd(na_wb_rd), .wb_data(na_wb_data), .fault(na_fault),
    .fault_cause(na_fault_cause), .fault_addr(na_fault_addr), .busy(na_busy)
  );

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          dly;        // done in cycle (start cycle + dly); NEVER = no done
    logic        exp_start;
    logic [31:0] exp_addr;   // effective address, for mem_address or fault_addr
    logic        exp_wb;
    logic        exp_fault;
    logic [1:0]  exp_cause;
    int          exp_ev;     // cycle of wb/fault pulse, 0 if none
    int          exp_end;    // first cycle busy is low again
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; mem_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                           input logic [31:0] off, input logic [31:0] data, input logic [4:0] rd);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_base = base;
    req_offset = off; req_store_data = data; req_rd = rd;
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int starts = 0, start_cyc = -1, done_cyc = -1, end_cyc = -1, ev_cyc = 0;
    int wb_cnt = 0, fault_cnt = 0, bad_mem = 0;
    logic [31:0] s_addr = '0, s_wdata = '0, got_wb_data = '0, got_faddr = '0;
    logic [2:0]  s_mode = '0;
    logic        s_we = 1'b0, in_mem;
    logic [4:0]  got_wb_rd = '0;
    logic [1:0]  got_cause = '0;
    string       tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    check({tag, "_ready_before"}, 32'(req_ready), 32'd1);
    drive_req(v.store, v.f3, v.base, v.off, v.data, v.rd);
    mem_read_data = v.rdata;
    for (int c = 1; c < 40 && end_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (mem_start) begin
        starts++; start_cyc = c;
        s_addr = mem_address; s_mode = mem_mode; s_we = mem_write_enable; s_wdata = mem_write_data;
      end
      in_mem = busy && !fault && (starts > 0) && (done_cyc < 0);
      if (in_mem) begin
        if (mem_address !== v.exp_addr || mem_mode !== v.f3 ||
            mem_write_enable !== v.store || mem_write_data !== v.data) bad_mem++;
      end else if (mem_address !== 32'd0 || mem_mode !== 3'd0 ||
                   mem_write_enable !== 1'b0 || mem_write_data !== 32'd0) begin
        bad_mem++;
      end
      if (wb_valid) begin
        wb_cnt++; if (ev_cyc == 0) ev_cyc = c;
        got_wb_rd = wb_rd; got_wb_data = wb_data;
      end
      if (fault) begin
        fault_cnt++; if (ev_cyc == 0) ev_cyc = c;
        got_cause = fault_cause; got_faddr = fault_addr;
      end
      if (!busy) end_cyc = c;
      mem_done = (v.dly != NEVER) && (starts > 0) && (c == start_cyc + v.dly);
      if (mem_done) done_cyc = c;
    end
    mem_done = 1'b0;
    check({tag, "_start_count"}, 32'(starts), 32'(v.exp_start));
    if (v.exp_start) begin
      check({tag, "_mem_address"}, s_addr, v.exp_addr);
      check({tag, "_mem_mode"}, 32'(s_mode), 32'(v.f3));
      check({tag, "_mem_we"}, 32'(s_we), 32'(v.store));
      check({tag, "_mem_wdata"}, s_wdata, v.data);
    end
    check({tag, "_mem_bus_cycles"}, 32'(bad_mem), 32'd0);
    check({tag, "_wb_count"}, 32'(wb_cnt), 32'(v.exp_wb));
    if (v.exp_wb) begin
      check({tag, "_wb_rd"}, 32'(got_wb_rd), 32'(v.rd));
      check({tag, "_wb_data"}, got_wb_data, v.rdata);
    end
    check({tag, "_fault_count"}, 32'(fault_cnt), 32'(v.exp_fault));
    if (v.exp_fault) begin
      check({tag, "_fault_cause"}, 32'(got_cause), 32'(v.exp_cause));
      check({tag, "_fault_addr"}, got_faddr, v.exp_addr);
    end
    check({tag, "_event_cycle"}, 32'(ev_cyc), 32'(v.exp_ev));
    check({tag, "_end_cycle"}, 32'(end_cyc), 32'(v.exp_end));
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  vec_t vecs[14];

  initial begin
    int wb_seen, fault_seen, na_starts, na_wbs, main_faults;
    logic [31:0] na_addr, na_data;
    logic [1:0]  main_cause;

    // store f3   base          offset        data          rdata         rd    dly    st  addr          wb  flt cause ev  end
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0000_0004, 32'hAAAA_5555, 32'hDEAD_BEEF, 5'd5,  4,     1'b1, 32'h0000_0104, 1'b1, 1'b0, 2'd0, 6,  7};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0200, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0,         5'd0,  4,     1'b1, 32'h0000_01FF, 1'b0, 1'b0, 2'd0, 0,  6};
    vecs[2]  = '{1'b0, 3'b001, 32'h0000_0100, 32'h0000_0001, 32'h0,         32'h0,         5'd3,  NEVER, 1'b0, 32'h0000_0101, 1'b0, 1'b1, 2'd0, 1,  2};
    vecs[3]  = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_0003, 32'h0000_00AB, 32'h0,         5'd0,  NEVER, 1'b0, 32'h0000_0003, 1'b0, 1'b1, 2'd2, 1,  2};
    vecs[4]  = '{1'b1, 3'b001, 32'h0000_0200, 32'h0000_0001, 32'h0000_0055, 32'h0,         5'd0,  NEVER, 1'b0, 32'h0000_0201, 1'b0, 1'b1, 2'd1, 1,  2};
    vecs[5]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0000_0002, 32'h0,         32'h0,         5'd2,  NEVER, 1'b0, 32'h0000_0102, 1'b0, 1'b1, 2'd0, 1,  2};
    vecs[6]  = '{1'b0, 3'b011, 32'h0000_0008, 32'h0000_0000, 32'h0,         32'h0,         5'd2,  NEVER, 1'b0, 32'h0000_0008, 1'b0, 1'b1, 2'd2, 1,  2};
    vecs[7]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0000_0002, 32'h0,         32'h0000_FFFF, 5'd31, 1,     1'b1, 32'h0000_0102, 1'b1, 1'b0, 2'd0, 3,  4};
    vecs[8]  = '{1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,         5'd0,  2,     1'b1, 32'h0000_0004, 1'b0, 1'b0, 2'd0, 0,  4};
    vecs[9]  = '{1'b0, 3'b100, 32'h0000_0007, 32'h0000_0000, 32'h0,         32'h0000_0080, 5'd1,  3,     1'b1, 32'h0000_0007, 1'b1, 1'b0, 2'd0, 5,  6};
    vecs[10] = '{1'b1, 3'b110, 32'h0000_0010, 32'h0000_0002, 32'h0,         32'h0,         5'd0,  NEVER, 1'b0, 32'h0000_0012, 1'b0, 1'b1, 2'd2, 1,  2};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0000_0000, 32'h0,         32'h1357_9BDF, 5'd9,  16,    1'b1, 32'h0000_0020, 1'b1, 1'b0, 2'd0, 18, 19};
    vecs[12] = '{1'b0, 3'b010, 32'h0000_0040, 32'h0000_0000, 32'h0,         32'h0,         5'd7,  NEVER, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 2'd3, 18, 19};
    vecs[13] = '{1'b0, 3'b100, 32'h0000_0040, 32'h0000_0001, 32'h0,         32'h0000_0080, 5'd0,  2,     1'b1, 32'h0000_0041, 1'b0, 1'b0, 2'd0, 0,  5};

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_base = '0;
    req_offset = '0; req_store_data = '0; req_rd = '0; mem_done = 1'b0;
    mem_active = 1'b0; mem_read_data = '0;
    do_reset();

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_outs", {mem_address[15:0], 8'(mem_mode), 6'(mem_start), 1'(mem_write_enable), 1'(|mem_write_data)}, 32'd0);
    check("rst_wb", {wb_data[23:0], 3'(wb_rd), 5'(wb_valid)}, 32'd0);
    check("rst_fault", {fault_addr[28:0], fault_cause, fault}, 32'd0);

    for (int i = 0; i < 14; i++) run_txn(i, vecs[i]);

    // Reset while a load waits on the controller: silent abort, late done ignored.
    do_reset();
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0, 32'h0000_0020, 32'h0, 5'd6);
    mem_read_data = 32'h5A5A_5A5A;
    wb_seen = 0; fault_seen = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (wb_valid) wb_seen++;
      if (fault) fault_seen++;
    end
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_mem_start", 32'(mem_start), 32'd0);
    check("midrst_mem_address", mem_address, 32'd0);
    check("midrst_mem_ctrl", {mem_write_data[27:0], 1'(mem_write_enable), mem_mode}, 32'd0);
    mem_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_done = 1'b0;
      if (wb_valid) wb_seen++;
      if (fault) fault_seen++;
    end
    check("midrst_no_wb", 32'(wb_seen), 32'd0);
    check("midrst_no_fault", 32'(fault_seen), 32'd0);
    check("midrst_idle_after_late_done", 32'(busy), 32'd0);

    // Misaligned halfword load against both alignment settings.
    do_reset();
    @(negedge clk);
    drive_req(1'b0, 3'b001, 32'h0000_0100, 32'h0000_0001, 32'h0, 5'd4);
    mem_read_data = 32'hFFFF_8001;
    na_starts = 0; na_wbs = 0; main_faults = 0;
    na_addr = '0; na_data = '0; main_cause = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (na_mem_start) begin na_starts++; na_addr = na_mem_address; end
      if (na_wb_valid) begin na_wbs++; na_data = na_wb_data; end
      if (fault) begin main_faults++; main_cause = fault_cause; end
      mem_done = (c == 3);
    end
    mem_done = 1'b0;
    check("noalign_start_count", 32'(na_starts), 32'd1);
    check("noalign_address", na_addr, 32'h0000_0101);
    check("noalign_wb_count", 32'(na_wbs), 32'd1);
    check("noalign_wb_data", na_data, 32'hFFFF_8001);
    check("align_fault_count", 32'(main_faults), 32'd1);
    check("align_fault_cause", 32'(main_cause), 32'd0);
    check("noalign_idle", 32'(na_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
